ppi_phase_bank: RTL and testbench

//  Polyphase interpolator sub-filter bank; sits directly upstream of the commutator.
//  Per accepted input sample, computes all L phase outputs with one time-multiplexed MAC.

---
 rtl/ppi_phase_bank.sv | 151 +++++++++++++++
 tb/tb_ppi_phase_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_phase_bank.sv
// Polyphase interpolator sub-filter bank: one time-multiplexed MAC evaluates all L phases
// per input sample and publishes them as a single packed word for the downstream commutator.
module ppi_phase_bank #(
   parameter int L     = 4,
   parameter int T     = 4,
   parameter int IW    = 4,
   parameter int CW    = 8,
   parameter int OW    = 4,
   parameter int SHIFT = 0,
   parameter logic [L*T*CW-1:0] COEF = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_ena,
   input  logic [IW-1:0]     i_data,
   output logic [L*OW-1:0]   o_data,
   output logic              o_valid,
   output logic              o_busy,
   output logic              o_overrun
);

   localparam int PW     = (L > 1) ? $clog2(L) : 1;
   localparam int TW     = (T > 1) ? $clog2(T) : 1;
   localparam int MW     = IW + CW;
   localparam int AW     = IW + CW + $clog2(T);
   localparam int RW     = AW + 1;
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic signed [RW-1:0] RND_ADD = (SHIFT > 0) ? (RW'(1) << RND_SH) : '0;
   localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (OW - 1)) - 1);
   localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Round-half-up then arithmetic shift; one guard bit keeps the rounding add from wrapping.
   function automatic logic signed [RW-1:0] round_shift(input logic signed [AW-1:0] v);
      logic signed [RW-1:0] r;
      r = {v[AW-1], v};
      r = (r + RND_ADD) >>> SHIFT;
      return r;
   endfunction

   function automatic logic signed [OW-1:0] saturate(input logic signed [RW-1:0] v);
      logic signed [RW-1:0] c;
      if (v > SAT_MAX)      c = SAT_MAX;
      else if (v < SAT_MIN) c = SAT_MIN;
      else                  c = v;
      return c[OW-1:0];
   endfunction

   logic [1:0]              state_q, state_d;
   logic [PW-1:0]           p_q, p_d;
   logic [TW-1:0]           t_q, t_d;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic signed [IW-1:0]    x_q [T];
   logic signed [IW-1:0]    x_d [T];
   logic signed [OW-1:0]    shadow_q [L];
   logic signed [OW-1:0]    shadow_d [L];
   logic [L*OW-1:0]         o_data_q, o_data_d;
   logic                    valid_q, valid_d;
   logic                    ovr_q, ovr_d;

   logic signed [CW-1:0]    coef;
   logic signed [MW-1:0]    prod;
   logic signed [AW-1:0]    sum;
   logic signed [OW-1:0]    res;
   int                      cidx;

   // Datapath: tap t of phase p uses prototype coefficient h[t*L + p].
   always_comb begin
      cidx = int'(t_q) * L + int'(p_q);
      coef = $signed(COEF[cidx*CW +: CW]);
      prod = x_q[t_q] * coef;
      sum  = (t_q == '0) ? AW'(prod) : (acc_q + AW'(prod));
      res  = saturate(round_shift(sum));
   end

   always_comb begin
      state_d  = state_q;
      p_d      = p_q;
      t_d      = t_q;
      acc_d    = acc_q;
      x_d      = x_q;
      shadow_d = shadow_q;
      o_data_d = o_data_q;
      valid_d  = 1'b0;
      ovr_d    = i_ena && (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (i_ena) begin
               x_d[0] = $signed(i_data);
               for (int t = 1; t < T; t++) x_d[t] = x_q[t-1];
               p_d     = '0;
               t_d     = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d = sum;
            if (t_q == TW'(T - 1)) begin
               shadow_d[p_q] = res;
               t_d           = '0;
               if (p_q == PW'(L - 1)) begin
                  // Publish on the final MAC edge so o_valid coincides with the DONE cycle.
                  for (int p = 0; p < L; p++) o_data_d[p*OW +: OW] = shadow_d[p];
                  valid_d = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  p_d = p_q + PW'(1);
               end
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         p_q      <= '0;
         t_q      <= '0;
         acc_q    <= '0;
         for (int t = 0; t < T; t++) x_q[t] <= '0;
         for (int p = 0; p < L; p++) shadow_q[p] <= '0;
         o_data_q <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         p_q      <= p_d;
         t_q      <= t_d;
         acc_q    <= acc_d;
         x_q      <= x_d;
         shadow_q <= shadow_d;
         o_data_q <= o_data_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign o_data    = o_data_q;
   assign o_valid   = valid_q;
   assign o_busy    = (state_q != ST_IDLE);
   assign o_overrun = ovr_q;

endmodule

// File: tb/tb_ppi_phase_bank.sv
// Directed bench for ppi_phase_bank: two instances (SHIFT=0 and SHIFT=2) share stimulus,
// a reference model fills per-instance scoreboards that are drained on each o_valid.
module tb_ppi_phase_bank;

   localparam logic [127:0] H = 128'h100F0E0D0C0B0A090807060504030201;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ena = 1'b0;
   logic [3:0]  din = '0;
   logic [31:0] od0, od2;
   logic        vld0, vld2, bsy0, bsy2, ovr0, ovr2;

   int          n_eval = 0;
   int          n_fail = 0;
   int          mx [4];
   logic [31:0] q0 [$];
   logic [31:0] q2 [$];
   logic [31:0] last0, last2;

   always #5 clk = ~clk;

   ppi_phase_bank #(.L(4), .T(4), .IW(4), .CW(8), .OW(8), .SHIFT(0), .COEF(H)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_data(din),
      .o_data(od0), .o_valid(vld0), .o_busy(bsy0), .o_overrun(ovr0));

   ppi_phase_bank #(.L(4), .T(4), .IW(4), .CW(8), .OW(8), .SHIFT(2), .COEF(H)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_data(din),
      .o_data(od2), .o_valid(vld2), .o_busy(bsy2), .o_overrun(ovr2));

   // Reference: y_p = sum_t x[t]*h[4t+p], h[n]=n+1, optional round/shift, clamp to 8 bits.
   function automatic logic [31:0] model(input int sh);
      logic [31:0] r;
      int s;
      r = '0;
      for (int p = 0; p < 4; p++) begin
         s = 0;
         for (int t = 0; t < 4; t++) s += mx[t] * (t * 4 + p + 1);
         if (sh > 0) s = (s + (1 << (sh - 1))) >>> sh;
         if (s > 127) s = 127;
         else if (s < -128) s = -128;
         r[p*8 +: 8] = s[7:0];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) mx[i] = 0;
      q0.delete();
      q2.delete();
   endtask

   task automatic push_sample(input int d);
      for (int i = 3; i > 0; i--) mx[i] = mx[i-1];
      mx[0] = d;
      q0.push_back(model(0));
      q2.push_back(model(2));
   endtask

   // Caller is at cycle 0 with the DUT idle; returns at cycle 1.
   task automatic send(input int d);
      push_sample(d);
      ena = 1'b1;
      din = d[3:0];
      step();
      ena = 1'b0;
      din = '0;
   endtask

   // Enters at cycle n0 after the accepted i_ena, returns at cycle 18 (one past DONE).
   task automatic wait_out(input string tag, input int n0, input bit ena_at_done);
      logic [31:0] e0, e2;
      int n;
      n = n0;
      while (!vld0 && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, 32'(vld0), 32'd1);
      chk({tag, "_lat"}, 32'(n), 32'd17);
      chk({tag, "_valid2"}, 32'(vld2), 32'(vld0));
      e0 = (q0.size() > 0) ? q0.pop_front() : 32'hDEADBEEF;
      e2 = (q2.size() > 0) ? q2.pop_front() : 32'hDEADBEEF;
      chk({tag, "_d0"}, od0, e0);
      chk({tag, "_d2"}, od2, e2);
      last0 = od0;
      last2 = od2;
      if (ena_at_done) begin
         ena = 1'b1;
         din = 4'd3;
      end
      step();
      ena = 1'b0;
      din = '0;
      chk({tag, "_pulse"}, 32'(vld0), 32'd0);
      chk({tag, "_idle"}, 32'(bsy0), 32'd0);
      chk({tag, "_ovr"}, 32'(ovr0), 32'(ena_at_done));
      chk({tag, "_hold"}, od0, last0);
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 4; i++) mx[i] = 0;

      // Reset state
      idle(3);
      rst = 1'b0;
      chk("rst_data0", od0, 32'h0);
      chk("rst_data2", od2, 32'h0);
      chk("rst_flags", {29'd0, vld0, bsy0, ovr0}, 32'h0);
      chk("rst_flags2", {29'd0, vld2, bsy2, ovr2}, 32'h0);

      // Impulse response, one sample every 20 cycles
      send(1);
      chk("imp_busy", 32'(bsy0), 32'd1);
      wait_out("imp1", 1, 1'b0);
      chk("imp1_lit", last0, 32'h04030201);
      for (int k = 2; k <= 5; k++) begin
         idle(2);
         send(0);
         wait_out($sformatf("imp%0d", k), 1, 1'b0);
         case (k)
            2: chk("imp2_lit", last0, 32'h08070605);
            3: chk("imp3_lit", last0, 32'h0C0B0A09);
            4: chk("imp4_lit", last0, 32'h100F0E0D);
            default: chk("imp5_lit", last0, 32'h00000000);
         endcase
      end

      // Saturation both ways
      for (int k = 0; k < 4; k++) begin
         idle(2);
         send(7);
         wait_out("satp", 1, 1'b0);
      end
      chk("satp_lit", last0, 32'h7F7F7F7F);
      for (int k = 0; k < 4; k++) begin
         idle(2);
         send(-8);
         wait_out("satn", 1, 1'b0);
      end
      chk("satn_lit", last0, 32'h80808080);

      // Rounding on the SHIFT=2 instance
      do_reset();
      send(1);
      wait_out("rnd", 1, 1'b0);
      chk("rnd_lit", last2, 32'h01010100);

      // Overrun during MAC, then during DONE
      do_reset();
      send(1);
      idle(2);
      chk("ovr_c3", 32'(ovr0), 32'd0);
      ena = 1'b1;
      din = 4'd5;
      step();
      ena = 1'b0;
      din = '0;
      chk("ovr_c4", 32'(ovr0), 32'd1);
      chk("ovr_c4_busy", 32'(bsy0), 32'd1);
      step();
      chk("ovr_c5", 32'(ovr0), 32'd0);
      wait_out("ovr", 5, 1'b0);
      chk("ovr_lit", last0, 32'h04030201);
      send(0);
      wait_out("ovr_next", 1, 1'b1);
      chk("ovr_next_lit", last0, 32'h08070605);
      send(0);
      wait_out("ovr_done", 1, 1'b0);
      chk("ovr_done_lit", last0, 32'h0C0B0A09);

      // Reset in the middle of a MAC sequence
      do_reset();
      ena = 1'b1;
      din = 4'd1;
      step();
      ena = 1'b0;
      din = '0;
      idle(5);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(bsy0), 32'd0);
      chk("mid_rst_data", od0, 32'h0);
      idle(2);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) mx[i] = 0;
      seen = 0;
      for (int i = 0; i < 24; i++) begin
         if (vld0 || vld2) seen++;
         step();
      end
      chk("mid_rst_novalid", 32'(seen), 32'd0);
      chk("mid_rst_hold", od0, 32'h0);
      send(1);
      wait_out("mid_rst_next", 1, 1'b0);
      chk("mid_rst_lit", last0, 32'h04030201);

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule
